bp_io_wormhole_responder: RTL

- Endpoint that terminates the IO command network and generates the IO response network traffic. It is the responder for the wormhole IO links that tiles drive through their io_cmd/io_resp routers.
- Accepts one wormhole command packet at a time on the local port of an io_cmd router and performs a single-word read or write on a simple device-side memory port.
- Returns a wormhole response packet to the requester's coordinate on the io_resp link.
- Used to attach IO devices (CSR blocks, host bridges) to the IO NoC.

---
 rtl/bp_io_wormhole_responder.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/bp_io_wormhole_responder.sv
// IO network endpoint: takes one wormhole command packet, does a single-word device access,
// and sends a wormhole response back to the requester.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// RX_HDR   | idle, waiting for a command header flit
// RX_DATA  | waiting for the first payload flit (write data)
// DRAIN    | discarding surplus payload flits, count_r = flits still to come
// MEM_REQ  | presenting the request to the device until it is accepted
// MEM_WAIT | waiting for the device response pulse
// TX_HDR   | sending the response header
// TX_DATA  | sending the read-data flit
module bp_io_wormhole_responder
  #(parameter int flit_width_p = 64
   , parameter int cord_width_p = 8
   , parameter int len_width_p = 4
   , parameter int addr_width_p = 40
   , localparam int link_width_lp = flit_width_p + 2
   )
   (input  logic                     clk_i
   , input  logic                     reset_i
   , input  logic [cord_width_p-1:0]  my_cord_i
   , input  logic [link_width_lp-1:0] io_cmd_link_i
   , output logic [link_width_lp-1:0] io_cmd_link_o
   , input  logic [link_width_lp-1:0] io_resp_link_i
   , output logic [link_width_lp-1:0] io_resp_link_o
   , output logic                     mem_v_o
   , output logic                     mem_w_o
   , output logic [addr_width_p-1:0]  mem_addr_o
   , output logic [flit_width_p-1:0]  mem_data_o
   , input  logic                     mem_ready_and_i
   , input  logic                     mem_resp_v_i
   , input  logic [flit_width_p-1:0]  mem_resp_data_i
   );

   localparam int len_lsb_lp  = cord_width_p;
   localparam int src_lsb_lp  = len_lsb_lp + len_width_p;
   localparam int w_bit_lp    = src_lsb_lp + cord_width_p;
   localparam int addr_lsb_lp = w_bit_lp + 1;
   localparam int err_bit_lp  = addr_lsb_lp + addr_width_p;

   typedef enum logic [2:0] {
      RX_HDR   = 3'd0,
      RX_DATA  = 3'd1,
      DRAIN    = 3'd2,
      MEM_REQ  = 3'd3,
      MEM_WAIT = 3'd4,
      TX_HDR   = 3'd5,
      TX_DATA  = 3'd6
   } state_e;

   state_e state_r, state_n;

   logic                    cmd_v;
   logic [flit_width_p-1:0] cmd_data;
   logic                    resp_ready;
   logic [len_width_p-1:0]  hdr_len;
   logic [cord_width_p-1:0] hdr_src;
   logic                    hdr_w;
   logic [addr_width_p-1:0] hdr_addr;

   logic [cord_width_p-1:0] src_r;
   logic                    write_r;
   logic [addr_width_p-1:0] addr_r;
   logic [len_width_p-1:0]  len_r;
   logic [len_width_p-1:0]  count_r;
   logic                    err_r;
   logic [flit_width_p-1:0] wdata_r;
   logic [flit_width_p-1:0] rdata_r;

   logic                    resp_has_data;
   logic [flit_width_p-1:0] resp_hdr;
   logic                    cmd_ready;
   logic                    resp_v;
   logic [flit_width_p-1:0] resp_data;

   assign cmd_v      = io_cmd_link_i[link_width_lp-1];
   assign cmd_data   = io_cmd_link_i[link_width_lp-2:1];
   assign resp_ready = io_resp_link_i[0];

   assign hdr_len  = cmd_data[len_lsb_lp +: len_width_p];
   assign hdr_src  = cmd_data[src_lsb_lp +: cord_width_p];
   assign hdr_w    = cmd_data[w_bit_lp];
   assign hdr_addr = cmd_data[addr_lsb_lp +: addr_width_p];

   logic unused_bits;
   assign unused_bits = ^{io_cmd_link_i[0], io_resp_link_i[link_width_lp-1:1],
                          cmd_data[cord_width_p-1:0], cmd_data[flit_width_p-1:err_bit_lp]};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= RX_HDR;
      end else begin
         state_r <= state_n;
      end
   end

   always_comb begin
      state_n = state_r;
      case (state_r)
         RX_HDR: begin
            if (cmd_v) begin
               if (hdr_len == '0) begin
                  state_n = hdr_w ? TX_HDR : MEM_REQ;
               end else begin
                  state_n = RX_DATA;
               end
            end
         end
         RX_DATA: begin
            if (cmd_v) begin
               if (len_r == len_width_p'(1)) begin
                  state_n = write_r ? MEM_REQ : TX_HDR;
               end else begin
                  state_n = DRAIN;
               end
            end
         end
         DRAIN: begin
            // exit on the last flit so the counter never has to pass through zero
            if (cmd_v && (count_r == len_width_p'(1))) begin
               state_n = err_r ? TX_HDR : MEM_REQ;
            end
         end
         MEM_REQ: begin
            if (mem_ready_and_i) state_n = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (mem_resp_v_i) state_n = TX_HDR;
         end
         TX_HDR: begin
            if (resp_ready) state_n = resp_has_data ? TX_DATA : RX_HDR;
         end
         TX_DATA: begin
            if (resp_ready) state_n = RX_HDR;
         end
         default: state_n = RX_HDR;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         src_r   <= '0;
         write_r <= 1'b0;
         addr_r  <= '0;
         len_r   <= '0;
         count_r <= '0;
         err_r   <= 1'b0;
         wdata_r <= '0;
         rdata_r <= '0;
      end else begin
         case (state_r)
            RX_HDR: begin
               if (cmd_v) begin
                  src_r   <= hdr_src;
                  write_r <= hdr_w;
                  addr_r  <= hdr_addr;
                  len_r   <= hdr_len;
                  count_r <= '0;
                  err_r   <= hdr_w && (hdr_len == '0);
                  wdata_r <= '0;
                  rdata_r <= '0;
               end
            end
            RX_DATA: begin
               if (cmd_v) begin
                  wdata_r <= cmd_data;
                  count_r <= len_r - len_width_p'(1);
                  err_r   <= !write_r;
               end
            end
            DRAIN: begin
               if (cmd_v) count_r <= count_r - len_width_p'(1);
            end
            MEM_WAIT: begin
               if (mem_resp_v_i && !write_r) rdata_r <= mem_resp_data_i;
            end
            default: ;
         endcase
      end
   end

   assign resp_has_data = !write_r && !err_r;

   always_comb begin
      resp_hdr = '0;
      resp_hdr[cord_width_p-1:0]            = src_r;
      resp_hdr[len_lsb_lp +: len_width_p]   = len_width_p'(resp_has_data);
      resp_hdr[src_lsb_lp +: cord_width_p]  = my_cord_i;
      resp_hdr[w_bit_lp]                    = write_r;
      resp_hdr[addr_lsb_lp +: addr_width_p] = addr_r;
      resp_hdr[err_bit_lp]                  = err_r;
   end

   // every output is forced low while reset is asserted, even mid-packet
   always_comb begin
      cmd_ready  = 1'b0;
      resp_v     = 1'b0;
      resp_data  = '0;
      mem_v_o    = 1'b0;
      mem_w_o    = 1'b0;
      mem_addr_o = '0;
      mem_data_o = '0;
      if (!reset_i) begin
         cmd_ready  = (state_r == RX_HDR) || (state_r == RX_DATA) || (state_r == DRAIN);
         mem_v_o    = (state_r == MEM_REQ);
         mem_w_o    = write_r;
         mem_addr_o = addr_r;
         mem_data_o = wdata_r;
         if (state_r == TX_HDR) begin
            resp_v    = 1'b1;
            resp_data = resp_hdr;
         end else if (state_r == TX_DATA) begin
            resp_v    = 1'b1;
            resp_data = rdata_r;
         end
      end
   end

   assign io_cmd_link_o  = {1'b0, {flit_width_p{1'b0}}, cmd_ready};
   assign io_resp_link_o = {resp_v, resp_data, 1'b0};

endmodule
